ex_muldiv_unit: RTL and testbench

- Execute-stage multi-cycle RV32M multiply/divide unit. It sits directly downstream of the ID/EX pipeline register and consumes its decoded operands, funct3 and rd.
- Runs an iterative shift-add multiply or restoring divide. It raises a stall to the hazard logic so ID/EX holds while busy.
- It presents a registered result with a one-cycle done pulse for the EX/MEM register.

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/ex_muldiv_unit_if.sv | 26 ++
 rtl/muldiv_iter.sv | 79 +++++++
 rtl/ex_muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension execute unit: funct3 codes,
// opcode constants, FSM state type and funct3 decode helpers.
package rv32_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OP_RTYPE      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the ID/EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in, flush,
    input  stall, busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in, flush,
    output stall, busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative datapath on unsigned magnitudes: shift-add multiply or restoring
// divide, one step per cycle, sharing a single 2*XLEN accumulator.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              last
);

  localparam int CNT_W = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step_s;
  logic [XLEN-1:0]   b_q, b_d;
  logic              div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     mul_sum_s, shifted_s, diff_s;

  // Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]}
              + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    shifted_s = acc_q[2*XLEN-1:XLEN-1];
    diff_s    = shifted_s - {1'b0, b_q};
    if (div_q) begin
      if (diff_s[XLEN]) begin
        acc_step_s = {shifted_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_step_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_q[XLEN-1:1]};
    end
  end

  // Next-state selection for load, step and hold.
  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = {{XLEN{1'b0}}, a_mag};
      b_d   = b_mag;
      div_d = is_div;
      cnt_d = {CNT_W{1'b0}};
    end else if (step) begin
      acc_d = acc_step_s;
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {(2*XLEN){1'b0}};
      b_q   <= {XLEN{1'b0}};
      div_q <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_nxt = acc_step_s;
  assign last    = (cnt_q == CNT_W'(XLEN-1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: fixed-latency FSM, sign handling,
// divide special cases and the registered result handed to EX/MEM.
module ex_muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_unit_if.slave  mdu
);

  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d;
  logic            sign_a_q, sign_a_d, sign_res_q, sign_res_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] special_val_q, special_val_d, result_q, result_d;

  logic              accept_s, neg_a_s, neg_b_s, div0_s, ovf_s, last_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, spec_val_s, fix_s, quo_s, rem_s;
  logic [2*XLEN-1:0] acc_nxt_s, prod_s;

  assign accept_s = (state_q == IDLE) && mdu.start && !mdu.flush;
  assign neg_a_s  = f3_signed_a(mdu.funct3) && mdu.rs1_val[XLEN-1];
  assign neg_b_s  = f3_signed_b(mdu.funct3) && mdu.rs2_val[XLEN-1];
  assign a_mag_s  = neg_a_s ? (ZERO - mdu.rs1_val) : mdu.rs1_val;
  assign b_mag_s  = neg_b_s ? (ZERO - mdu.rs2_val) : mdu.rs2_val;
  assign div0_s   = f3_is_div(mdu.funct3) && (mdu.rs2_val == ZERO);
  assign ovf_s    = f3_is_div(mdu.funct3) && f3_signed_b(mdu.funct3)
                 && (mdu.rs1_val == INT_MIN) && (mdu.rs2_val == ALL_ONES);

  // Special-case results are fixed at issue; the op still runs full length.
  always_comb begin
    if (div0_s) begin
      spec_val_s = f3_is_rem(mdu.funct3) ? mdu.rs1_val : ALL_ONES;
    end else if (ovf_s) begin
      spec_val_s = f3_is_rem(mdu.funct3) ? ZERO : INT_MIN;
    end else begin
      spec_val_s = ZERO;
    end
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept_s),
    .step    (state_q == RUN),
    .is_div  (f3_is_div(mdu.funct3)),
    .a_mag   (a_mag_s),
    .b_mag   (b_mag_s),
    .acc_nxt (acc_nxt_s),
    .last    (last_s)
  );

  // Sign fix-up on the final iteration's value.
  always_comb begin
    prod_s = sign_res_q ? ({(2*XLEN){1'b0}} - acc_nxt_s) : acc_nxt_s;
    quo_s  = sign_res_q ? (ZERO - acc_nxt_s[XLEN-1:0]) : acc_nxt_s[XLEN-1:0];
    rem_s  = sign_a_q ? (ZERO - acc_nxt_s[2*XLEN-1:XLEN]) : acc_nxt_s[2*XLEN-1:XLEN];
    if (special_q) begin
      fix_s = special_val_q;
    end else begin
      case (f3_q)
        F3_MUL:                       fix_s = prod_s[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: fix_s = prod_s[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:              fix_s = quo_s;
        F3_REM, F3_REMU:              fix_s = rem_s;
        default:                      fix_s = ZERO;
      endcase
    end
  end

  // Control FSM.
  always_comb begin
    state_d       = state_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    sign_a_d      = sign_a_q;
    sign_res_d    = sign_res_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    result_d      = result_q;
    rd_out_d      = rd_out_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d       = RUN;
          f3_d          = mdu.funct3;
          rd_d          = mdu.rd_in;
          sign_a_d      = neg_a_s;
          sign_res_d    = neg_a_s ^ neg_b_s;
          special_d     = div0_s || ovf_s;
          special_val_d = spec_val_s;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (mdu.flush) begin
          state_d = IDLE;
        end else if (last_s) begin
          state_d  = DONE;
          result_d = fix_s;
          rd_out_d = rd_q;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      f3_q          <= 3'b000;
      rd_q          <= 5'd0;
      sign_a_q      <= 1'b0;
      sign_res_q    <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= ZERO;
      result_q      <= ZERO;
      rd_out_q      <= 5'd0;
    end else begin
      state_q       <= state_d;
      f3_q          <= f3_d;
      rd_q          <= rd_d;
      sign_a_q      <= sign_a_d;
      sign_res_q    <= sign_res_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      result_q      <= result_d;
      rd_out_q      <= rd_out_d;
    end
  end

  // stall covers the issue cycle so ID/EX holds on the very first cycle.
  assign mdu.stall  = rst_n && (accept_s || (state_q == RUN));
  assign mdu.busy   = (state_q != IDLE);
  assign mdu.done   = (state_q == DONE);
  assign mdu.result = result_q;
  assign mdu.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed plan scenarios plus
// randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import rv32_pkg::*;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [31:0] res, exp_last;
  logic [4:0]  rdo;
  int          sc, cy;
  logic        got;

  ex_muldiv_unit_if #(.XLEN(XLEN)) mdu_if();

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[31:0]; end
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op at the current (negedge) time and wait for done.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    mdu_if.start   = 1'b1;
    mdu_if.funct3  = f3;
    mdu_if.rs1_val = a;
    mdu_if.rs2_val = b;
    mdu_if.rd_in   = rd;
    got = 1'b0;
    res = 32'd0;
    rdo = 5'd0;
    cy  = 0;
    #1;
    sc = mdu_if.stall ? 1 : 0;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      cy++;
      if (mdu_if.stall) sc++;
      if (mdu_if.done) begin
        got = 1'b1;
        res = mdu_if.result;
        rdo = mdu_if.rd_out;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no done, required done within 100 cycles");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mdu_if.start = 1'b1;
    mdu_if.flush = 1'b0;
    mdu_if.funct3 = 3'd0;
    mdu_if.rs1_val = 32'd3;
    mdu_if.rs2_val = 32'd4;
    mdu_if.rd_in = 5'd1;
    #12;
    checks++; if (mdu_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", mdu_if.stall); end
    checks++; if (mdu_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", mdu_if.busy); end
    checks++; if (mdu_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", mdu_if.done); end
    checks++; if (mdu_if.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h required 0", mdu_if.result); end
    checks++; if (mdu_if.rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d required 0", mdu_if.rd_out); end
    mdu_if.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h required ffffffeb", res); end
    checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rd: got %0d required 5", rdo); end
    checks++; if (sc !== 33) begin errors++; $display("FAIL mul_stall_cycles: got %0d required 33", sc); end
    checks++; if (cy !== 33) begin errors++; $display("FAIL mul_latency: got %0d required 33", cy); end
    exp_last = 32'hFFFF_FFEB;
    @(negedge clk);
    checks++; if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) begin errors++; $display("FAIL mul_after_done: got busy=%b done=%b required 0 0", mdu_if.busy, mdu_if.done); end
    checks++; if (mdu_if.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h required ffffffeb", mdu_if.result); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  f3s [3];
    logic [31:0] as  [3];
    logic [31:0] exps[3];
    f3s = '{3'd1, 3'd3, 3'd2};
    as  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    for (int k = 0; k < 3; k++) begin
      do_op(f3s[k], as[k], as[k], 5'(k + 10));
      checks++; if (res !== exps[k]) begin errors++; $display("FAIL upper_mul_%0d: got %h required %h", k, res, exps[k]); end
      checks++; if (sc !== 33 || cy !== 33) begin errors++; $display("FAIL b2b_timing_%0d: got stall=%0d latency=%0d required 33 33", k, sc, cy); end
      @(negedge clk);
    end
    exp_last = exps[2];
  endtask

  task automatic test_div;
    logic [2:0]  f3s [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [31:0] exps[8];
    f3s  = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    as   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int k = 0; k < 8; k++) begin
      do_op(f3s[k], as[k], bs[k], 5'(k + 1));
      checks++; if (res !== exps[k]) begin errors++; $display("FAIL div_case_%0d: got %h required %h", k, res, exps[k]); end
      checks++; if (cy !== 33) begin errors++; $display("FAIL div_latency_%0d: got %0d required 33", k, cy); end
      @(negedge clk);
    end
    exp_last = exps[7];
  endtask

  task automatic test_flush;
    mdu_if.start = 1'b1;
    mdu_if.funct3 = 3'd4;
    mdu_if.rs1_val = 32'd1000;
    mdu_if.rs2_val = 32'd3;
    mdu_if.rd_in = 5'd9;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    mdu_if.flush = 1'b1;
    @(posedge clk);
    #1;
    mdu_if.flush = 1'b0;
    @(negedge clk);
    checks++; if (mdu_if.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b required 0", mdu_if.done); end
    checks++; if (mdu_if.busy !== 1'b0 || mdu_if.stall !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b stall=%b required 0 0", mdu_if.busy, mdu_if.stall); end
    checks++; if (mdu_if.result !== exp_last) begin errors++; $display("FAIL flush_result_hold: got %h required %h", mdu_if.result, exp_last); end
    do_op(3'd5, 32'd9, 32'd3, 5'd7);
    checks++; if (res !== 32'd3 || rdo !== 5'd7) begin errors++; $display("FAIL flush_restart: got %h/%0d required 3/7", res, rdo); end
    exp_last = 32'd3;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    mdu_if.start = 1'b1;
    mdu_if.funct3 = 3'd5;
    mdu_if.rs1_val = 32'd100;
    mdu_if.rs2_val = 32'd7;
    mdu_if.rd_in = 5'd4;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    mdu_if.start = 1'b1;
    mdu_if.rs1_val = 32'd9;
    mdu_if.rs2_val = 32'd3;
    mdu_if.rd_in = 5'd12;
    #1;
    checks++; if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0 || mdu_if.stall !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b stall=%b required 0 0 0", mdu_if.busy, mdu_if.done, mdu_if.stall); end
    checks++; if (mdu_if.result !== 32'd0 || mdu_if.rd_out !== 5'd0) begin errors++; $display("FAIL midreset_regs: got %h/%0d required 0/0", mdu_if.result, mdu_if.rd_out); end
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mdu_if.busy !== 1'b1) begin errors++; $display("FAIL midreset_restart: got busy=%b required 1", mdu_if.busy); end
    mdu_if.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (mdu_if.done) begin
        got = 1'b1;
        res = mdu_if.result;
        rdo = mdu_if.rd_out;
      end
    end
    checks++; if (!got || res !== 32'd3 || rdo !== 5'd12) begin errors++; $display("FAIL midreset_result: got done=%b %h/%0d required 1 3/12", got, res, rdo); end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    logic [4:0]  rd;
    for (int k = 0; k < 40; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      e  = ref_model(f3, a, b);
      do_op(f3, a, b, rd);
      checks++; if (res !== e || rdo !== rd) begin errors++; $display("FAIL rand_%0d f3=%0d a=%h b=%h: got %h/%0d required %h/%0d", k, f3, a, b, res, rdo, e, rd); end
      @(negedge clk);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_last = 32'd0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_div();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish before 2000000 time units");
    $fatal(1);
  end

endmodule
